// File: rtl/key_step_pkg.sv
// rtl/key_step_pkg.sv - shared state encoding and counter sizing for key_step_ctrl
package key_step_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } key_state_t;

  // Bits needed to hold max(a, b, c) - 1; never less than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
//
// Ports:
//   clk     in   destination clock
//   reset_n in   asynchronous active-low reset, forces both flops to RESET_VAL
//   d       in   asynchronous input
//   q       out  synchronized copy of d, two clk edges of latency
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - pushbutton debounce and single-step strobe with auto-repeat
//
// Ports:
//   clk           in   board clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   key_n         in   raw pushbutton, active-low, asynchronous to clk
//   repeat_en     in   enables auto-repeat while the key is held
//   step_pulse    out  one-cycle strobe per accepted press and per repeat event
//   release_pulse out  one-cycle strobe per accepted release
//   key_level     out  debounced key state, 1 = pressed
module key_step_ctrl
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic step_pulse,
  output logic release_pulse,
  output logic key_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic       ks;
  key_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic       step_nxt, release_nxt, level_nxt;

  sync2 #(.RESET_VAL(1'b1)) u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_n),
    .q       (ks)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      step_pulse    <= 1'b0;
      release_pulse <= 1'b0;
      key_level     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      step_pulse    <= step_nxt;
      release_pulse <= release_nxt;
      key_level     <= level_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    step_nxt    = 1'b0;
    release_nxt = 1'b0;
    level_nxt   = key_level;

    case (state)
      IDLE: begin
        if (!ks) state_nxt = DB_PRESS;
      end

      DB_PRESS: begin
        if (ks) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          step_nxt  = 1'b1;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      HELD: begin
        if (ks) begin
          state_nxt = DB_RELEASE;
        end else if (repeat_en && cnt == RD_LAST) begin
          state_nxt = REPEAT;
          step_nxt  = 1'b1;
        end else if (cnt != RD_LAST) begin
          // Parks at RD_LAST with repeat off, so enabling repeat later
          // fires on the next cycle instead of waiting a full delay.
          cnt_nxt = cnt + CW'(1);
        end
      end

      REPEAT: begin
        if (ks) begin
          state_nxt = DB_RELEASE;
        end else if (!repeat_en) begin
          state_nxt = HELD;
        end else if (cnt == RP_LAST) begin
          step_nxt = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DB_RELEASE: begin
        // A short release glitch returns to HELD with the repeat delay restarted.
        if (!ks) begin
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        level_nxt = 1'b0;
      end
    endcase

    // Every state change starts its own count from zero.
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule

// File: doc/key_step_ctrl.md
Name: key_step_ctrl

Overview:
- Debounce and single-step stage for one DE2 pushbutton.
- Sits directly upstream of the intel8080 core: it replaces the raw KEY[0] connection and feeds the core one clean step strobe per press.
- Runs on the 50 MHz board clock. Optional auto-repeat allows continuous stepping while the key is held.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples required to accept a press or a release; must be ≥2.
- REPEAT_DELAY, 25000000, cycles held in HELD before the first auto-repeat pulse; must be ≥2.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses; must be ≥2.

Ports:
- clk  input  1  board clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_n  input  1  raw pushbutton, active-low, asynchronous to clk.
- repeat_en  input  1  enables auto-repeat; sampled every cycle.
- step_pulse  output  1  one-cycle strobe, one per accepted press and one per auto-repeat event.
- release_pulse  output  1  one-cycle strobe when a debounced release is accepted.
- key_level  output  1  debounced key state, 1 = pressed.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset state: both synchronizer flops = 1 (released), state = IDLE, cnt = 0, step_pulse = 0, release_pulse = 0, key_level = 0. Reset takes effect immediately, including mid-debounce or mid-repeat.
- Synchronizer: key_n passes through 2 flops; the FSM sees only the second flop, ks.
- Counter: cnt is wide enough for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1. cnt is cleared on every state change.
- Outputs: all outputs are registered. step_pulse and release_pulse default to 0 each cycle.
- IDLE: if ks = 0, go to DB_PRESS.
- DB_PRESS:
  - If ks = 1, return to IDLE (bounce rejected, no pulse).
  - Else if cnt = DEBOUNCE_CYCLES-1, go to HELD; set step_pulse = 1 and key_level = 1.
  - Else cnt++.
- HELD:
  - If ks = 1, go to DB_RELEASE.
  - Else if repeat_en and cnt = REPEAT_DELAY-1, go to REPEAT; set step_pulse = 1.
  - Else cnt++. If repeat_en = 0, cnt saturates at REPEAT_DELAY-1 with no pulse.
- REPEAT:
  - If ks = 1, go to DB_RELEASE.
  - Else if repeat_en = 0, go to HELD.
  - Else if cnt = REPEAT_PERIOD-1, set step_pulse = 1 and cnt = 0.
  - Else cnt++.
- DB_RELEASE:
  - If ks = 0, go to HELD (release glitch rejected; key_level stays 1; repeat delay restarts).
  - Else if cnt = DEBOUNCE_CYCLES-1, go to IDLE; set key_level = 0 and release_pulse = 1.
  - Else cnt++.
- Press latency: take edge 0 as the first edge that samples key_n low, with key_n stable afterwards. step_pulse is high for exactly the cycle after edge DEBOUNCE_CYCLES+2. key_level rises on the same edge.
- Release latency: symmetric. release_pulse is high for the cycle after edge DEBOUNCE_CYCLES+2, counted from the first edge sampling key_n high.
- Pulse exclusivity: step_pulse and release_pulse are never high in the same cycle. Neither is ever wider than one cycle.
- repeat_en toggling: has effect only in HELD and REPEAT.
- Illegal state encodings: recover to IDLE.

Decomposition:
- Shared package key_step_pkg holds:
  - the state enum: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE (3-bit encoding);
  - a constant-width function returning the counter width from the parameters.
- One sub-module: sync2, a 2-flop synchronizer with asynchronous active-low reset and a reset value parameter (here 1). It is reused for the other KEY inputs at top level.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3.
- Reset: reset_n = 0 with key_n toggling. Required: step_pulse = 0, release_pulse = 0, key_level = 0 throughout. After reset_n = 1 with key_n = 1, no pulse for 20 cycles.
- Clean press/release, repeat_en = 0: key_n low from edge 0 for 30 cycles. Required: exactly one step_pulse, after edge 6; key_level = 1 from edge 6. key_n high at edge 40: release_pulse after edge 46, key_level = 0.
- Bounce rejection: key_n low 2 cycles, high 2 cycles, repeated 5 times, then high. Required: no step_pulse, key_level stays 0.
- Auto-repeat, repeat_en = 1: key_n held low 30 cycles from edge 0. Required: step_pulse after edges 6, 16, 19, 22, 25, 28 only.
- Release glitch: in HELD, key_n high for 2 cycles, then low. Required: no release_pulse, key_level stays 1, no step_pulse.
- Reset mid-DB_PRESS: key_n low from edge 0, reset_n = 0 at edge 3, key_n high before reset is released. Required: no step_pulse at any time, key_level = 0, state IDLE.
